// File: rtl/md_pkg.sv
// Shared types and defaults for the execute-stage multiply/divide unit.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith_op(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 signed/unsigned multiply and divide producing {hi,lo}.
// Latency: zero (pure combinational). Backpressure: none, caller samples when it starts.
// Division by zero returns 0 and raises div_zero so the caller can skip the commit.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [31:0] divisor;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        sgn;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    prod_s   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u   = {32'd0, rs} * {32'd0, rt};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    sgn      = (op == MD_DIV);
    abs_rs   = (sgn && rs[31]) ? (32'd0 - rs) : rs;
    abs_rt   = (sgn && rt[31]) ? (32'd0 - rt) : rt;
    div_zero = is_div_op(op) && (rt == 32'd0);
    divisor  = (rt == 32'd0) ? 32'd1 : abs_rt;
    q_u      = abs_rs / divisor;
    r_u      = abs_rs % divisor;
    neg_q    = sgn && (rs[31] ^ rt[31]);
    neg_r    = sgn && rs[31];

    res = 64'd0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {(neg_r ? (32'd0 - r_u) : r_u), (neg_q ? (32'd0 - q_u) : q_u)};
      MD_DIVU:  res = {r_u, q_u};
      default:  res = 64'd0;
    endcase
    if (div_zero) res = 64'd0;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; drives the start/busy stall handshake.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles; result visible first cycle busy=0.
// Backpressure: none accepted; ops arriving while busy are dropped (hazard unit prevents them).
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_t      md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  md_state_t   state;
  logic [5:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [63:0] arith_res;
  logic        arith_dz;

  md_arith u_arith (
    .op       (md_op),
    .rs       (rs_data),
    .rt       (rt_data),
    .res      (arith_res),
    .div_zero (arith_dz)
  );

  assign start = is_arith_op(md_op) && !flush;

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi;
      MD_MFLO: md_out = lo;
      default: md_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      busy    <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pend_hi <= arith_res[63:32];
            pend_lo <= arith_res[31:0];
            pend_dz <= arith_dz;
            cnt     <= is_div_op(md_op) ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
            busy    <= 1'b1;
            state   <= S_RUN;
          end else if (!flush && md_op == MD_MTHI) begin
            hi <= rs_data;
          end else if (!flush && md_op == MD_MTLO) begin
            lo <= rs_data;
          end
        end
        S_RUN: begin
          // Anything on md_op here is ignored; flush cannot abort an op in flight.
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            busy  <= 1'b0;
            state <= S_IDLE;
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, busy window and handshake checks.
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  md_op_t      md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  // Issue an op in the current cycle, then count busy cycles (-1 on timeout).
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    md_op = op; rs_data = a; rt_data = b; flush = 1'b0;
    @(posedge clk); #1;
    md_op = MD_NONE;
    nb = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      nb++;
      @(posedge clk); #1;
    end
    if (busy) nb = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; md_op = MD_NONE; rs_data = 0; rt_data = 0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int nb;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, nb);
    n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", nb); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, nb);
    n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL multu_busy: got %0d want 5", nb); end
    n_cmp++; if (hi !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want 00000002", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
  endtask

  task automatic test_div();
    int nb;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, nb);
    n_cmp++; if (nb !== 10) begin n_err++; $display("FAIL div_busy: got %0d want 10", nb); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    run_op(MD_DIVU, 32'd7, 32'd2, nb);
    n_cmp++; if (nb !== 10) begin n_err++; $display("FAIL divu_busy: got %0d want 10", nb); end
    n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 00000003", lo); end
    n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 00000001", hi); end
  endtask

  task automatic test_div_zero();
    int nb;
    md_op = MD_MTHI; rs_data = 32'h1234; flush = 1'b0;
    @(posedge clk); #1;
    md_op = MD_MTLO; rs_data = 32'h5678;
    n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi: got %h want 00001234", hi); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    md_op = MD_MFHI;
    #1;
    n_cmp++; if (lo !== 32'h5678) begin n_err++; $display("FAIL mtlo: got %h want 00005678", lo); end
    n_cmp++; if (md_out !== 32'h1234) begin n_err++; $display("FAIL mfhi_out: got %h want 00001234", md_out); end
    run_op(MD_DIVU, 32'd99, 32'd0, nb);
    n_cmp++; if (nb !== 10) begin n_err++; $display("FAIL divz_busy: got %0d want 10", nb); end
    n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL divz_hi: got %h want 00001234", hi); end
    n_cmp++; if (lo !== 32'h5678) begin n_err++; $display("FAIL divz_lo: got %h want 00005678", lo); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_flush();
    int seen_busy;
    md_op = MD_MULT; rs_data = 32'd3; rt_data = 32'd4; flush = 1'b1;
    #1;
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL flush_start: got %b want 0", start); end
    seen_busy = 0;
    @(posedge clk); #1;
    md_op = MD_NONE; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) seen_busy++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen_busy !== 0) begin n_err++; $display("FAIL flush_busy: got %0d busy cycles want 0", seen_busy); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL flush_mult_lo: got %h want 80000000", lo); end
    md_op = MD_MTLO; rs_data = 32'hAA; flush = 1'b1;
    @(posedge clk); #1;
    md_op = MD_NONE; flush = 1'b0;
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL flush_mtlo: got %h want 80000000", lo); end
  endtask

  task automatic test_reset_mid();
    md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7; flush = 1'b0;
    @(posedge clk); #1;
    md_op = MD_NONE;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy1: got %b want 1", busy); end
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL rstmid_lo: got %h want 0", lo); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL rstmid_nocommit: got hi=%h lo=%h want 0/0", hi, lo);
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int nb;
    run_op(MD_MULT, 32'd7, 32'd6, nb);
    n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL b2b_busy1: got %0d want 5", nb); end
    md_op = MD_MFLO;
    #1;
    n_cmp++; if (md_out !== 32'd42) begin n_err++; $display("FAIL b2b_mflo: got %h want 0000002a", md_out); end
    md_op = MD_MULT; rs_data = 32'd3; rt_data = 32'd5;
    #1;
    n_cmp++; if (start !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %b want 1", start); end
    run_op(MD_MULT, 32'd3, 32'd5, nb);
    n_cmp++; if (nb !== 5) begin n_err++; $display("FAIL b2b_busy2: got %0d want 5", nb); end
    n_cmp++; if (lo !== 32'd15 || hi !== 32'd0) begin
      n_err++; $display("FAIL b2b_result: got hi=%h lo=%h want 0/0000000f", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
